// File: rtl/asteroid_field_if.sv
// Bundle between asteroid_field and its neighbours: frame sync, ship and bullet
// positions in; asteroid object list, hit pulses and score out.
interface asteroid_field_if #(
  parameter int obj_num = 4
);
  logic                     vs;
  logic                     game_screen;
  logic [9:0]               BallX;
  logic [9:0]               BallY;
  logic [9:0]               bullet_x;
  logic [9:0]               bullet_y;
  logic                     bullet_activate;
  logic [obj_num-1:0][9:0]  Obj_X;
  logic [obj_num-1:0][9:0]  Obj_Y;
  logic [obj_num-1:0][9:0]  Obj_Size;
  logic [obj_num-1:0]       Obj_act;
  logic                     bullet_hit;
  logic                     ship_hit;
  logic [15:0]              score;

  // Game side: drives sync/positions, consumes the object list.
  modport master (
    output vs, game_screen, BallX, BallY, bullet_x, bullet_y, bullet_activate,
    input  Obj_X, Obj_Y, Obj_Size, Obj_act, bullet_hit, ship_hit, score
  );

  // Asteroid field side.
  modport slave (
    input  vs, game_screen, BallX, BallY, bullet_x, bullet_y, bullet_activate,
    output Obj_X, Obj_Y, Obj_Size, Obj_act, bullet_hit, ship_hit, score
  );
endinterface

// File: rtl/asteroid_field.sv
// Asteroid object manager. On each vsync falling edge it walks every slot once
// (move / bullet hit / ship hit), then runs one spawn step. All object state
// changes happen in those few cycles right after the frame tick, i.e. in vblank.
module asteroid_field #(
  parameter int obj_num      = 4,
  parameter int OBJ_SIZE     = 32,
  parameter int SPAWN_PERIOD = 45,
  parameter int SCREEN_H     = 480
) (
  input logic             Clk,
  input logic             Reset,
  asteroid_field_if.slave bus
);

  localparam int          IDX_W     = (obj_num > 1) ? $clog2(obj_num) : 1;
  localparam logic [10:0] SZ        = 11'(OBJ_SIZE);
  localparam logic [10:0] SZ_M1     = 11'(OBJ_SIZE - 1);
  localparam logic [10:0] SCR_H     = 11'(SCREEN_H);
  localparam logic [15:0] PERIOD_M1 = 16'(SPAWN_PERIOD - 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(obj_num - 1);

  typedef enum logic [1:0] {IDLE, MOVE, SPAWN} state_t;

  state_t             state_reg;
  logic [IDX_W-1:0]   idx_reg;
  logic [9:0]         obj_x_reg [obj_num];
  logic [9:0]         obj_y_reg [obj_num];
  logic [2:0]         speed_reg [obj_num];
  logic [obj_num-1:0] obj_act_reg;
  logic [15:0]        lfsr_reg;
  logic [15:0]        score_reg;
  logic [15:0]        frame_cnt_reg;
  logic               vs_d_reg;
  logic               bullet_hit_reg;
  logic               ship_hit_reg;

  logic               tick;
  logic [10:0]        cur_x, cur_y, y_next;
  logic [10:0]        bx, by;
  logic [10:0]        ship_l, ship_r, ship_t, ship_b;
  logic               bullet_in, ship_ov;
  logic               spawn_found;
  logic [IDX_W-1:0]   spawn_idx;

  assign tick = vs_d_reg & ~bus.vs;

  // Collision and motion terms for the slot being visited, widened to 11 bits
  // so box edges near the bottom/right of the screen cannot wrap.
  always_comb begin
    cur_x  = {1'b0, obj_x_reg[idx_reg]};
    cur_y  = {1'b0, obj_y_reg[idx_reg]};
    y_next = cur_y + {8'd0, speed_reg[idx_reg]};
    bx     = {1'b0, bus.bullet_x};
    by     = {1'b0, bus.bullet_y};
    ship_l = (bus.BallX >= 10'd17) ? {1'b0, bus.BallX - 10'd17} : 11'd0;
    ship_r = {1'b0, bus.BallX} + 11'd17;
    ship_t = (bus.BallY >= 10'd16) ? {1'b0, bus.BallY - 10'd16} : 11'd0;
    ship_b = {1'b0, bus.BallY} + 11'd16;
    bullet_in = bus.bullet_activate &&
                (bx >= cur_x) && (bx < cur_x + SZ) &&
                (by >= cur_y) && (by < cur_y + SZ);
    ship_ov   = (cur_x <= ship_r) && (cur_x + SZ_M1 >= ship_l) &&
                (cur_y <= ship_b) && (cur_y + SZ_M1 >= ship_t);
  end

  // Lowest-index free slot for the spawn step.
  always_comb begin
    spawn_found = 1'b0;
    spawn_idx   = '0;
    for (int k = obj_num - 1; k >= 0; k--) begin
      if (!obj_act_reg[k]) begin
        spawn_found = 1'b1;
        spawn_idx   = k[IDX_W-1:0];
      end
    end
  end

  // Free-running Fibonacci LFSR (taps 16,14,13,11); only Reset reseeds it.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      lfsr_reg <= 16'hACE1;
    end else begin
      lfsr_reg <= {lfsr_reg[14:0], lfsr_reg[15] ^ lfsr_reg[13] ^ lfsr_reg[12] ^ lfsr_reg[10]};
    end
  end

  // Frame FSM: IDLE waits for a tick, MOVE visits one slot per cycle, SPAWN once.
  always_ff @(posedge Clk) begin
    if (Reset || !bus.game_screen) begin
      state_reg      <= IDLE;
      idx_reg        <= '0;
      obj_act_reg    <= '0;
      score_reg      <= '0;
      frame_cnt_reg  <= '0;
      vs_d_reg       <= 1'b1;
      bullet_hit_reg <= 1'b0;
      ship_hit_reg   <= 1'b0;
      for (int k = 0; k < obj_num; k++) begin
        obj_x_reg[k] <= '0;
        obj_y_reg[k] <= '0;
        speed_reg[k] <= 3'd1;
      end
    end else begin
      vs_d_reg       <= bus.vs;
      bullet_hit_reg <= 1'b0;
      ship_hit_reg   <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (tick) begin
            state_reg <= MOVE;
            idx_reg   <= '0;
          end
        end
        MOVE: begin
          if (obj_act_reg[idx_reg]) begin
            if (bullet_in) begin
              obj_act_reg[idx_reg] <= 1'b0;
              bullet_hit_reg       <= 1'b1;
              score_reg            <= score_reg + 16'd1;
            end else if (ship_ov) begin
              obj_act_reg[idx_reg] <= 1'b0;
              ship_hit_reg         <= 1'b1;
            end else begin
              obj_y_reg[idx_reg] <= y_next[9:0];
              if (y_next >= SCR_H) begin
                obj_act_reg[idx_reg] <= 1'b0;
              end
            end
          end
          if (idx_reg == LAST_IDX) begin
            state_reg <= SPAWN;
          end else begin
            idx_reg <= idx_reg + 1'b1;
          end
        end
        SPAWN: begin
          state_reg <= IDLE;
          if (frame_cnt_reg == PERIOD_M1) begin
            frame_cnt_reg <= '0;
            if (spawn_found) begin
              obj_act_reg[spawn_idx] <= 1'b1;
              obj_y_reg[spawn_idx]   <= '0;
              obj_x_reg[spawn_idx]   <= {1'b0, lfsr_reg[8:0]} + 10'd64;
              speed_reg[spawn_idx]   <= {1'b0, lfsr_reg[10:9]} + 3'd1;
            end
          end else begin
            frame_cnt_reg <= frame_cnt_reg + 16'd1;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign bus.Obj_act    = obj_act_reg;
  assign bus.bullet_hit = bullet_hit_reg;
  assign bus.ship_hit   = ship_hit_reg;
  assign bus.score      = score_reg;

  generate
    for (genvar gi = 0; gi < obj_num; gi++) begin : g_obj
      assign bus.Obj_X[gi]    = obj_x_reg[gi];
      assign bus.Obj_Y[gi]    = obj_y_reg[gi];
      assign bus.Obj_Size[gi] = 10'(OBJ_SIZE);
    end
  endgenerate

endmodule

// File: tb/tb_asteroid_field.sv
// Bench for asteroid_field: random frames against a slot-list reference model,
// expected responses queued per cycle and compared by an independent monitor.
module tb_asteroid_field;
  localparam int N = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  asteroid_field_if #(.obj_num(N)) bus();
  asteroid_field #(.obj_num(N)) dut (.Clk(clk), .Reset(rst), .bus(bus));

  typedef struct packed {
    int                 at;
    logic               bh;
    logic               sh;
    logic               full;
    logic [N-1:0][9:0]  x;
    logic [N-1:0][9:0]  y;
    logic [N-1:0]       act;
    logic [15:0]        score;
  } rec_t;

  rec_t sb_q[$];
  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;
  logic [15:0] tb_lfsr;

  // Reference model state
  int m_x[N], m_y[N], m_spd[N];
  bit m_act[N];
  int m_score, m_fc;

  function automatic logic [15:0] lfsr_step(input logic [15:0] l);
    return {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
  endfunction

  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) tb_lfsr <= rst ? 16'hACE1 : lfsr_step(tb_lfsr);

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s @cyc %0d: got %0h expected %0h", name, cyc, got, exp);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < N; i++) begin
      m_x[i] = 0; m_y[i] = 0; m_spd[i] = 1; m_act[i] = 0;
    end
    m_score = 0;
    m_fc = 0;
  endtask

  function automatic rec_t snap(input int at, input bit bh, input bit sh, input bit full);
    rec_t r;
    r.at = at; r.bh = bh; r.sh = sh; r.full = full;
    for (int i = 0; i < N; i++) begin
      r.x[i]   = 10'(m_x[i]);
      r.y[i]   = 10'(m_y[i]);
      r.act[i] = m_act[i];
    end
    r.score = 16'(m_score);
    return r;
  endfunction

  // One frame of the game rules on the slot list.
  task automatic model_frame(input bit bact, input int bx, input int by, input int sx,
                             input int sy, input logic [15:0] l,
                             output bit [N-1:0] bh, output bit [N-1:0] sh);
    int sl, st, k;
    bh = '0; sh = '0;
    sl = (sx > 17) ? sx - 17 : 0;
    st = (sy > 16) ? sy - 16 : 0;
    for (int i = 0; i < N; i++) begin
      if (m_act[i]) begin
        if (bact && bx >= m_x[i] && bx < m_x[i] + 32 && by >= m_y[i] && by < m_y[i] + 32) begin
          m_act[i] = 0; bh[i] = 1; m_score = (m_score + 1) % 65536;
        end else if (m_x[i] <= sx + 17 && m_x[i] + 31 >= sl &&
                     m_y[i] <= sy + 16 && m_y[i] + 31 >= st) begin
          m_act[i] = 0; sh[i] = 1;
        end else begin
          m_y[i] = m_y[i] + m_spd[i];
          if (m_y[i] >= 480) m_act[i] = 0;
        end
      end
    end
    if (m_fc == 44) begin
      m_fc = 0;
      k = -1;
      for (int i = N - 1; i >= 0; i--) if (!m_act[i]) k = i;
      if (k >= 0) begin
        m_act[k] = 1; m_y[k] = 0;
        m_x[k]   = int'(l[8:0]) + 64;
        m_spd[k] = int'(l[10:9]) + 1;
      end
    end else begin
      m_fc++;
    end
  endtask

  // Issue one frame tick (call at a negedge); inputs held until the update is over.
  task automatic do_frame(input bit bact, input int bx, input int by, input int sx, input int sy);
    logic [15:0] l;
    int c0;
    bit [N-1:0] bh, sh;
    bus.bullet_activate = bact;
    bus.bullet_x = 10'(bx); bus.bullet_y = 10'(by);
    bus.BallX = 10'(sx); bus.BallY = 10'(sy);
    bus.vs = 1'b0;
    c0 = cyc + 1;
    l = tb_lfsr;
    for (int k = 0; k < N + 1; k++) l = lfsr_step(l);
    sb_q.push_back(snap(c0, 0, 0, 0));
    model_frame(bact, bx, by, sx, sy, l, bh, sh);
    for (int i = 0; i < N; i++) sb_q.push_back(snap(c0 + 1 + i, bh[i], sh[i], 0));
    sb_q.push_back(snap(c0 + N + 1, 0, 0, 1));
    @(negedge clk);
    bus.vs = 1'b1;
    repeat (N + 3) @(negedge clk);
  endtask

  task automatic quiet_frame();
    do_frame(0, 0, 0, 5, 240);
  endtask

  task automatic rand_frame(input int quiet_pct);
    int act_idx[$];
    int pick, bx, by, sx, sy;
    bit bact;
    bact = 0; bx = 0; by = 0; sx = 5; sy = 240;
    for (int i = 0; i < N; i++) if (m_act[i]) act_idx.push_back(i);
    if (int'($urandom_range(0, 99)) >= quiet_pct && act_idx.size() > 0) begin
      pick = act_idx[$urandom_range(0, act_idx.size() - 1)];
      case ($urandom_range(0, 3))
        0: begin
          bact = ($urandom_range(0, 9) != 0);
          bx = m_x[pick] + int'($urandom_range(0, 33));
          by = m_y[pick] + int'($urandom_range(0, 33));
        end
        1: begin
          sx = m_x[pick] + int'($urandom_range(0, 66)) - 16;
          sy = m_y[pick] + int'($urandom_range(0, 66)) - 16;
        end
        2: begin
          bact = 1;
          bx = m_x[pick] + int'($urandom_range(0, 31));
          by = m_y[pick] + int'($urandom_range(0, 31));
          sx = m_x[pick] + 16;
          sy = m_y[pick] + 16;
        end
        default: begin
          bact = $urandom_range(0, 1);
          bx = $urandom_range(0, 1023); by = $urandom_range(0, 1023);
          sx = $urandom_range(0, 639);  sy = $urandom_range(0, 479);
        end
      endcase
      if (sy < 0) sy = 0;
    end
    do_frame(bact, bx, by, sx, sy);
  endtask

  // Monitor: compares DUT outputs whenever a queued expectation falls due.
  initial begin
    rec_t r;
    forever begin
      @(negedge clk);
      while (sb_q.size() > 0 && sb_q[0].at <= cyc) begin
        r = sb_q.pop_front();
        if (r.at < cyc) begin
          chk("sb_missed", 64'(cyc), 64'(r.at));
        end else begin
          chk("bullet_hit", 64'(bus.bullet_hit), 64'(r.bh));
          chk("ship_hit", 64'(bus.ship_hit), 64'(r.sh));
          if (r.full) begin
            chk("obj_act", 64'(bus.Obj_act), 64'(r.act));
            chk("obj_x", 64'(bus.Obj_X), 64'(r.x));
            chk("obj_y", 64'(bus.Obj_Y), 64'(r.y));
            chk("score", 64'(bus.score), 64'(r.score));
          end
        end
      end
    end
  end

  initial begin
    int c0, guard;
    rst = 1'b1;
    bus.vs = 1'b1; bus.game_screen = 1'b1;
    bus.BallX = 10'd5; bus.BallY = 10'd240;
    bus.bullet_x = '0; bus.bullet_y = '0; bus.bullet_activate = 1'b0;
    model_clear();
    sb_q.push_back(snap(1, 0, 0, 1));
    sb_q.push_back(snap(2, 0, 0, 1));
    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk("obj_size", 64'(bus.Obj_Size), {24'd0, {N{10'd32}}});

    // First spawn lands on the 45th frame, in slot 0 only.
    repeat (45) quiet_frame();
    chk("t1_act", 64'(bus.Obj_act), 64'(4'b0001));
    chk("t1_y0", 64'(bus.Obj_Y[0]), 64'd0);
    chk("t1_x_range", 64'(bus.Obj_X[0] >= 10'd64 && bus.Obj_X[0] <= 10'd575), 64'd1);

    // Mostly quiet: slots fill up, fall off the bottom, spawns get skipped.
    repeat (700) rand_frame(92);
    // Busy: lots of bullet/ship collisions.
    repeat (600) rand_frame(50);

    // game_screen dropped one cycle while the second slot is being visited.
    bus.bullet_activate = 1'b0; bus.BallX = 10'd5; bus.BallY = 10'd240;
    bus.vs = 1'b0;
    c0 = cyc + 1;
    model_clear();
    sb_q.push_back(snap(c0 + 2, 0, 0, 1));
    @(negedge clk); bus.vs = 1'b1;
    @(negedge clk); bus.game_screen = 1'b0;
    @(negedge clk); bus.game_screen = 1'b1;
    repeat (3) @(negedge clk);
    repeat (60) rand_frame(10);

    // Build up a score, then reset must clear it.
    guard = 0;
    while (m_score == 0 && guard < 300) begin
      rand_frame(0);
      guard++;
    end
    rst = 1'b1;
    model_clear();
    sb_q.push_back(snap(cyc + 1, 0, 0, 1));
    @(negedge clk);
    rst = 1'b0;
    chk("reset_score", 64'(bus.score), 64'd0);
    repeat (50) rand_frame(80);

    repeat (10) @(negedge clk);
    chk("sb_drain", 64'(sb_q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
